// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, one recoded bit pair per clock.
// Operands widen to WIDTH+1 bits, so a single datapath covers both signed and unsigned products.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH+1:0]     r_acc;
  logic [WIDTH:0]       r_q;
  logic                 r_qm1;
  logic [WIDTH:0]       r_m;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;

  logic [WIDTH+1:0]     w_m_ext;
  logic [WIDTH+1:0]     w_sum;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_m_ext = {r_m[WIDTH], r_m};
  assign w_last  = (r_cnt == CW'(WIDTH));
  // Low 2*WIDTH bits of {acc,Q} after this cycle's arithmetic right shift.
  assign w_prod  = {w_sum[WIDTH-1:0], r_q[WIDTH:1]};

  // Booth add/subtract selected by {Q0, Q(-1)}.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, Booth iterations and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= {(WIDTH+2){1'b0}};
      r_q       <= {(WIDTH+1){1'b0}};
      r_qm1     <= 1'b0;
      r_m       <= {(WIDTH+1){1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // The extension bit records signed_mode for the rest of the operation.
            r_m   <= {signed_mode & a[WIDTH-1], a};
            r_q   <= {signed_mode & b[WIDTH-1], b};
            r_acc <= {(WIDTH+2){1'b0}};
            r_qm1 <= 1'b0;
            r_cnt <= {CW{1'b0}};
          end
        end
        S_CALC: begin
          r_acc <= {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
          r_q   <= {w_sum[0], r_q[WIDTH:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_product <= w_prod;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign busy    = (r_state == S_CALC) || (r_state == S_DONE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: a WIDTH=4 and a WIDTH=8 instance,
// expected products queued at issue and compared by per-instance monitors on done.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst4, start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;
  logic        rst8, start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int tests = 0;
  int fails = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  int done8_cnt = 0;
  bit b2b_active = 1'b0;

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  booth_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mon4();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("product4", {24'd0, product4}, {24'd0, e});
        end
      end
    end
  endtask

  task automatic mon8();
    logic [15:0] e;
    int cyc = 0;
    int last_cyc = 0;
    int b2b_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!b2b_active) b2b_seen = 0;
      if (done8 === 1'b1) begin
        done8_cnt++;
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("product8", {16'd0, product8}, {16'd0, e});
        end
        if (b2b_active) begin
          if (b2b_seen > 0) chk("b2b_spacing", cyc - last_cyc, 32'd11);
          b2b_seen++;
        end
        last_cyc = cyc;
      end
    end
  endtask

  // Issue one WIDTH=4 multiply, then check latency, busy duration and hold.
  task automatic mul4(input logic sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int edges = 0;
    int busy_cyc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(exp);
    @(posedge clk); #1;
    start4 = 1'b0;
    if (busy4) busy_cyc++;
    while (!seen && edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (busy4) busy_cyc++;
      if (done4) seen = 1'b1;
    end
    chk("latency4", edges, 32'd5);
    chk("busy_cycles4", busy_cyc, 32'd6);
    @(posedge clk); #1;
    chk("idle_after_done4", {30'd0, busy4, done4}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("hold4", {24'd0, product4}, {24'd0, exp});
  endtask

  // One back-to-back WIDTH=8 operation with start held high.
  task automatic b2b_one(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input bit last);
    sm8 = sm; a8 = a; b8 = b;
    q8.push_back(exp);
    @(posedge clk); #1;
    if (last) begin
      start8 = 1'b0;
    end else begin
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    logic [7:0]  ra, rb;
    logic        rs;
    int          p;
    logic [15:0] rexp;
    rst4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    rst8 = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    fork
      mon4();
      mon8();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset4", {22'd0, busy4, done4, product4}, 32'd0);
    chk("reset8", {14'd0, busy8, done8, product8}, 32'd0);
    rst4 = 1'b0; rst8 = 1'b0;

    mul4(1'b1, 4'd3,   4'b1001, 8'hEB);
    mul4(1'b1, 4'b1000, 4'b1000, 8'h40);
    mul4(1'b1, 4'b1101, 4'b1001, 8'h15);
    mul4(1'b0, 4'hF,   4'hF,    8'hE1);
    mul4(1'b1, 4'hF,   4'hF,    8'h01);
    mul4(1'b0, 4'hA,   4'h3,    8'h1E);
    mul4(1'b1, 4'h7,   4'h8,    8'hC8);
    mul4(1'b0, 4'h0,   4'hF,    8'h00);

    // start pulsed mid-calculation with different operands must be ignored
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
    q8.push_back(16'h00C8);
    base = done8_cnt;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 start8 = 1'b1; sm8 = 1'b1; a8 = 8'h55; b8 = 8'h33;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("ignore_done_count", done8_cnt - base, 32'd1);

    // reset mid-calculation aborts without a done pulse
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0; start8 = 1'b0;
    chk("abort_state8", {14'd0, busy8, done8, product8}, 32'd0);
    base = done8_cnt;
    repeat (15) @(posedge clk);
    #1 chk("abort_no_done", done8_cnt - base, 32'd0);
    chk("abort_product", {16'd0, product8}, 32'd0);
    @(negedge clk);
    sm8 = 1'b1; a8 = 8'd5; b8 = 8'hFA; start8 = 1'b1;
    q8.push_back(16'hFFE2);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (15) @(posedge clk);

    // back-to-back with start held high: directed corners then reference-checked pairs
    @(negedge clk);
    b2b_active = 1'b1;
    start8 = 1'b1;
    b2b_one(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    b2b_one(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    b2b_one(1'b1, 8'hFF, 8'h80, 16'h0080, 1'b0);
    b2b_one(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0);
    b2b_one(1'b0, 8'h80, 8'h02, 16'h0100, 1'b0);
    b2b_one(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);
    b2b_one(1'b0, 8'h00, 8'hAB, 16'h0000, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) p = int'($signed(ra)) * int'($signed(rb));
      else    p = int'({24'd0, ra}) * int'({24'd0, rb});
      rexp = p[15:0];
      b2b_one(rs, ra, rb, rexp, i == 999);
    end
    repeat (15) @(posedge clk);
    #1 b2b_active = 1'b0;

    chk("queue4_drained", q4.size(), 32'd0);
    chk("queue8_drained", q8.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port signed_mode  input  1  operand interpretation: 1 = two's complement, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 The block SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 The block SHALL have port busy  output  1  high while a multiply is in progress (states CALC and DONE).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking product valid.
REQ-010 The block SHALL have port product  output  2*WIDTH  result; held stable from done until the next accepted start.

Function
REQ-011 The block SHALL implement radix-2 Booth recoding, one multiplier bit pair per clock, on internal WIDTH+1-bit operands: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; reset state is IDLE.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and signed_mode, clear the accumulator and the Booth extra bit Q(-1), clear the iteration counter, and enter CALC on that edge.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-015 Each CALC cycle SHALL examine {Q0,Q(-1)}: 01 -> accumulator += M; 10 -> accumulator -= M; 00/11 -> no add; then arithmetic right shift of {accumulator,Q,Q(-1)} by one, with the accumulator width WIDTH+2 so that no overflow occurs.
REQ-016 CALC SHALL perform exactly WIDTH+1 iterations; on the edge that completes the last iteration, the block SHALL load product with the low 2*WIDTH bits of the shifted result and enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in every other cycle.
REQ-018 Latency SHALL be fixed: done is high in the cycle following the (WIDTH+1)th rising edge after the edge that accepts start, independent of the operand values.
REQ-019 start asserted in CALC or DONE SHALL be ignored, with no queuing; a, b and signed_mode changes during CALC SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new multiply on the first IDLE cycle after DONE, i.e. back-to-back throughput of one result per WIDTH+3 cycles.
REQ-021 The result SHALL equal the exact mathematical product modulo 2^(2*WIDTH), including the most negative operand in signed mode, e.g. -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-022 busy SHALL be combinationally derived from state: busy=1 in CALC and DONE, busy=0 in IDLE.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL enter IDLE and set product=0, done=0, the counter to 0 and the internal registers to 0, regardless of state or start.
REQ-024 rst SHALL take priority over start on the same edge.
REQ-025 Reset during CALC SHALL abort the operation with no done pulse, and a start after rst deasserts SHALL be processed normally.

Verification
REQ-026 WIDTH=4, signed_mode=1, a=3, b=-7 -> done 5 edges after accept, product=8'hEB (-21), busy high for 6 cycles.
REQ-027 WIDTH=4, signed_mode=1, a=-8, b=-8 -> product=8'h40 (64); and a=-3, b=-7 -> 8'h15 (21).
REQ-028 WIDTH=4, signed_mode=0, a=4'hF, b=4'hF -> product=8'hE1 (225); the same operands with signed_mode=1 -> 8'h01.
REQ-029 WIDTH=8, start pulsed during CALC with different operands -> ignored; first product unchanged; done pulses once.
REQ-030 WIDTH=8, rst asserted mid-CALC -> product=0, no done pulse; subsequent 5*-6 signed -> product=16'hFFE2.
REQ-031 Randomised WIDTH=8: 1000 signed and unsigned operand pairs with start held high -> every product matches a reference multiply, with spacing of WIDTH+3 cycles between done pulses.
